layer_mem_responder: RTL and testbench
======================================

LAYER_MEM_RESPONDER -- requirements
Module: layer_mem_responder

Interface
REQ-001 SHALL provide: clk  in  1  clock, rising-edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL provide: start  in  1  host request to begin a convolution run.
REQ-003 SHALL provide: load_en  in  1, load_addr  in  12, load_data  in  20  host image-preload write port.
REQ-004 SHALL provide: ready  out  1  run-request strobe to the accelerator; busy  in  1  accelerator busy flag.
REQ-005 SHALL provide: iaddr  in  12 image read address; idata  out  20 image read data (signed).
REQ-006 SHALL provide: cwr  in  1, caddr_wr  in  12, cdata_wr  in  20, crd  in  1, caddr_rd  in  12, csel  in  3  layer-memory request port; cdata_rd  out  20 layer read data.
REQ-007 SHALL provide: done  out  1  run complete, sticky; wr_count  out  13  accepted layer writes this run.

Function
REQ-008 SHALL hold image memory 4096x20, L0 memory 4096x20, L1 memory 1024x20; contents not reset.
REQ-009 SHALL implement FSM IDLE, ARM, RUN, DONE; reset state IDLE.
REQ-010 IDLE: ready=0; start=1 -> ARM; wr_count cleared on that transition.
REQ-011 ARM: ready=1; busy sampled 1 -> RUN, ready low from the next cycle.
REQ-012 RUN: ready=0; busy sampled 0 -> DONE.
REQ-013 DONE: done=1; start=1 -> ARM, done cleared and wr_count cleared in the same cycle.
REQ-014 idata SHALL be registered: value after edge N equals image[iaddr sampled at edge N], every cycle, all states.
REQ-015 load_en=1 in IDLE or DONE SHALL write image[load_addr]=load_data at the edge; ignored in ARM/RUN.
REQ-016 cwr=1 with csel=3'd1 SHALL write L0[caddr_wr]=cdata_wr; csel=3'd3 SHALL write L1[caddr_wr[9:0]]; other csel values SHALL write nothing.
REQ-017 crd=1 SHALL register cdata_rd from L0[caddr_rd] (csel=1) or L1[caddr_rd[9:0]] (csel=3), one-cycle latency; other csel yields 0; crd=0 holds cdata_rd.
REQ-018 Simultaneous read and write of the same bank and address SHALL return the pre-write (old) data.
REQ-019 wr_count SHALL increment on each accepted write (csel 1 or 3) in any state, saturating at 8191.
REQ-020 cwr/crd SHALL be serviced in every state; busy glitches in ARM before it is first seen high SHALL have no effect.

Reset
REQ-021 reset SHALL force state IDLE, ready=0, done=0, idata=0, cdata_rd=0, wr_count=0 immediately.
REQ-022 reset asserted mid-run SHALL abort to IDLE; all memory contents retained; pending writes on that edge dropped.

Configuration
REQ-023 Macro LAYER_MEM_CHECK_EN defined: SHALL add output err (1 bit, reset 0, sticky until start in IDLE/DONE) set on cwr or crd with csel not 1 or 3, or csel=3 with caddr_*[11:10] != 0.
REQ-024 Macro LAYER_MEM_CHECK_EN undefined: err port absent; illegal accesses silently handled per REQ-016/017.

Verification
REQ-025 Preload image[0x041]=20'h12345, drive iaddr=0x041 -> idata=20'h12345 one cycle later.
REQ-026 start pulse in IDLE -> ready=1 next cycle; busy=1 -> ready=0 next cycle; busy=0 after 50 cycles -> done=1, state DONE.
REQ-027 cwr=1, csel=1, caddr_wr=0xFFF, cdata_wr=20'h0ABCD, then crd=1 csel=1 caddr_rd=0xFFF -> cdata_rd=20'h0ABCD next cycle; wr_count=1.
REQ-028 Same-cycle cwr and crd at L1 address 0x3FF holding 20'h00001, writing 20'h00002 -> cdata_rd=20'h00001, next read 20'h00002.
REQ-029 cwr with csel=2 -> no memory change, wr_count unchanged; with LAYER_MEM_CHECK_EN err=1.
REQ-030 reset asserted during RUN -> ready=0, done=0, wr_count=0 immediately; L0 data written earlier still readable.

Source files
------------

// File: rtl/layer_mem_responder_if.sv
// Host/accelerator bus bundle for layer_mem_responder.
// The master modport is the host/accelerator side; the slave modport is the responder.
// When LAYER_MEM_CHECK_EN is defined, the bundle also carries the sticky err flag.
interface layer_mem_responder_if;
  logic        start;
  logic        load_en;
  logic [11:0] load_addr;
  logic [19:0] load_data;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [19:0] idata;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [2:0]  csel;
  logic [19:0] cdata_rd;
  logic        done;
  logic [12:0] wr_count;
`ifdef LAYER_MEM_CHECK_EN
  logic        err;

  modport master (
    output start, load_en, load_addr, load_data, busy, iaddr,
    output cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
    input  ready, idata, cdata_rd, done, wr_count, err
  );
  modport slave (
    input  start, load_en, load_addr, load_data, busy, iaddr,
    input  cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
    output ready, idata, cdata_rd, done, wr_count, err
  );
`else
  modport master (
    output start, load_en, load_addr, load_data, busy, iaddr,
    output cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
    input  ready, idata, cdata_rd, done, wr_count
  );
  modport slave (
    input  start, load_en, load_addr, load_data, busy, iaddr,
    input  cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
    output ready, idata, cdata_rd, done, wr_count
  );
`endif
endinterface

// File: rtl/layer_mem_responder.sv
// Layer memory responder: image memory (4096x20), layer memories L0 (4096x20) and
// L1 (1024x20), plus a run handshake FSM (IDLE/ARM/RUN/DONE) toward an accelerator.
// Optional access checking is enabled with macro LAYER_MEM_CHECK_EN (adds err).
module layer_mem_responder (
  input logic             clk,
  input logic             reset,
  layer_mem_responder_if.slave mem_if
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_ready;
  logic        w_done;
  logic        w_run_clear;

  logic [19:0] r_img [0:4095];
  logic [19:0] r_l0  [0:4095];
  logic [19:0] r_l1  [0:1023];

  logic [19:0] r_idata;
  logic [19:0] r_cdata_rd;
  logic [12:0] r_wr_count;

  logic        w_img_we;
  logic        w_l0_we;
  logic        w_l1_we;
  logic        w_wr_accept;

  // Image preload is only allowed while the accelerator is not running.
  assign w_img_we    = mem_if.load_en && ((r_state == IDLE) || (r_state == DONE));
  assign w_l0_we     = mem_if.cwr && (mem_if.csel == 3'd1);
  assign w_l1_we     = mem_if.cwr && (mem_if.csel == 3'd3);
  assign w_wr_accept = w_l0_we || w_l1_we;

  // State register; reset aborts any run immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and Moore outputs; w_run_clear marks the start of a new run.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_done       = 1'b0;
    w_run_clear  = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_if.start) begin
          w_state_next = ARM;
          w_run_clear  = 1'b1;
        end
      end
      ARM: begin
        w_ready = 1'b1;
        if (mem_if.busy) w_state_next = RUN;
      end
      RUN: begin
        if (!mem_if.busy) w_state_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        if (mem_if.start) begin
          w_state_next = ARM;
          w_run_clear  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Memory writes; a write coinciding with reset is dropped, contents never cleared.
  always_ff @(posedge clk) begin
    if (!reset && w_img_we) r_img[mem_if.load_addr]      <= mem_if.load_data;
    if (!reset && w_l0_we)  r_l0[mem_if.caddr_wr]        <= mem_if.cdata_wr;
    if (!reset && w_l1_we)  r_l1[mem_if.caddr_wr[9:0]]   <= mem_if.cdata_wr;
  end

  // Registered image read every cycle; same-edge preload returns the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_idata <= '0;
    else       r_idata <= r_img[mem_if.iaddr];
  end

  // Registered layer read; holds when crd is low, unmapped banks read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cdata_rd <= '0;
    end else if (mem_if.crd) begin
      case (mem_if.csel)
        3'd1:    r_cdata_rd <= r_l0[mem_if.caddr_rd];
        3'd3:    r_cdata_rd <= r_l1[mem_if.caddr_rd[9:0]];
        default: r_cdata_rd <= '0;
      endcase
    end
  end

  // Accepted-write counter; restarting a run clears it and takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     r_wr_count <= '0;
    else if (w_run_clear)                          r_wr_count <= '0;
    else if (w_wr_accept && (r_wr_count != 13'h1FFF)) r_wr_count <= r_wr_count + 13'd1;
  end

`ifdef LAYER_MEM_CHECK_EN
  logic r_err;
  logic w_bad_wr;
  logic w_bad_rd;

  assign w_bad_wr = mem_if.cwr && ((mem_if.csel != 3'd1 && mem_if.csel != 3'd3) ||
                    (mem_if.csel == 3'd3 && mem_if.caddr_wr[11:10] != 2'b00));
  assign w_bad_rd = mem_if.crd && ((mem_if.csel != 3'd1 && mem_if.csel != 3'd3) ||
                    (mem_if.csel == 3'd3 && mem_if.caddr_rd[11:10] != 2'b00));

  // Sticky illegal-access flag, cleared when a new run is started.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= (w_run_clear ? 1'b0 : r_err) | w_bad_wr | w_bad_rd;
  end

  assign mem_if.err = r_err;
`endif

  assign mem_if.ready    = w_ready;
  assign mem_if.done     = w_done;
  assign mem_if.idata    = r_idata;
  assign mem_if.cdata_rd = r_cdata_rd;
  assign mem_if.wr_count = r_wr_count;

endmodule

// File: tb/tb_layer_mem_responder.sv
// Self-checking bench for layer_mem_responder: directed table, hand sequences for the
// run handshake and reset, write-count saturation, and a randomized phase against a
// behavioural model of the memories and run phases.
module tb_layer_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  layer_mem_responder_if bus();
  layer_mem_responder dut (.clk(clk), .reset(reset), .mem_if(bus));

  int checks = 0;
  int failures = 0;

  // Behavioural model: memory images with written-flags, run phase, counters.
  logic [19:0] m_img [4096];
  bit          m_img_v [4096];
  logic [19:0] m_l0 [4096];
  bit          m_l0_v [4096];
  logic [19:0] m_l1 [1024];
  bit          m_l1_v [1024];
  int          m_phase;   // 0 idle, 1 armed, 2 running, 3 finished
  int          m_wc;
  logic [19:0] m_idata;
  bit          m_idata_v;
  logic [19:0] m_crd;
  bit          m_crd_v;

  typedef struct {
    logic        cwr;
    logic        crd;
    logic [2:0]  csel;
    logic [11:0] wa;
    logic [11:0] ra;
    logic [19:0] wd;
    bit          chk;
    logic [19:0] exp_rd;
    logic [12:0] exp_wc;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0;
    bus.busy = 0; bus.iaddr = 0; bus.cwr = 0; bus.caddr_wr = 0; bus.cdata_wr = 0;
    bus.crd = 0; bus.caddr_rd = 0; bus.csel = 0;
  endtask

  task automatic model_reset();
    m_phase = 0; m_wc = 0;
    m_idata = 0; m_idata_v = 1;
    m_crd = 0; m_crd_v = 1;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    if (bus.crd) begin
      if (bus.csel == 3'd1) begin
        m_crd = m_l0[bus.caddr_rd]; m_crd_v = m_l0_v[bus.caddr_rd];
      end else if (bus.csel == 3'd3) begin
        m_crd = m_l1[bus.caddr_rd % 1024]; m_crd_v = m_l1_v[bus.caddr_rd % 1024];
      end else begin
        m_crd = 0; m_crd_v = 1;
      end
    end
    m_idata = m_img[bus.iaddr]; m_idata_v = m_img_v[bus.iaddr];
    if (bus.load_en && (m_phase == 0 || m_phase == 3)) begin
      m_img[bus.load_addr] = bus.load_data; m_img_v[bus.load_addr] = 1;
    end
    if (bus.cwr && (bus.csel == 3'd1 || bus.csel == 3'd3)) begin
      if (bus.csel == 3'd1) begin
        m_l0[bus.caddr_wr] = bus.cdata_wr; m_l0_v[bus.caddr_wr] = 1;
      end else begin
        m_l1[bus.caddr_wr % 1024] = bus.cdata_wr; m_l1_v[bus.caddr_wr % 1024] = 1;
      end
      if (m_wc < 8191) m_wc++;
    end
    case (m_phase)
      0, 3: if (bus.start) begin m_phase = 1; m_wc = 0; end
      1: if (bus.busy) m_phase = 2;
      2: if (!bus.busy) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic verify(input string tag);
    check($sformatf("%s.ready", tag), 32'(bus.ready), 32'(m_phase == 1));
    check($sformatf("%s.done", tag), 32'(bus.done), 32'(m_phase == 3));
    check($sformatf("%s.wr_count", tag), 32'(bus.wr_count), 32'(m_wc));
    if (m_idata_v) check($sformatf("%s.idata", tag), 32'(bus.idata), 32'(m_idata));
    if (m_crd_v)   check($sformatf("%s.cdata_rd", tag), 32'(bus.cdata_rd), 32'(m_crd));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 3'd1, 12'hFFF, 12'h000, 20'h0ABCD, 1'b0, 20'h00000, 13'd1};
    tbl[1] = '{1'b0, 1'b1, 3'd1, 12'h000, 12'hFFF, 20'h00000, 1'b1, 20'h0ABCD, 13'd1};
    tbl[2] = '{1'b1, 1'b0, 3'd3, 12'h3FF, 12'h000, 20'h00001, 1'b0, 20'h00000, 13'd2};
    tbl[3] = '{1'b1, 1'b1, 3'd3, 12'h3FF, 12'h3FF, 20'h00002, 1'b1, 20'h00001, 13'd3};
    tbl[4] = '{1'b0, 1'b1, 3'd3, 12'h000, 12'h3FF, 20'h00000, 1'b1, 20'h00002, 13'd3};
    tbl[5] = '{1'b1, 1'b0, 3'd2, 12'hFFF, 12'h000, 20'h11111, 1'b0, 20'h00000, 13'd3};
    tbl[6] = '{1'b0, 1'b1, 3'd1, 12'h000, 12'hFFF, 20'h00000, 1'b1, 20'h0ABCD, 13'd3};
    tbl[7] = '{1'b0, 1'b1, 3'd2, 12'h000, 12'hFFF, 20'h00000, 1'b1, 20'h00000, 13'd3};
    tbl[8] = '{1'b0, 1'b0, 3'd1, 12'h000, 12'hFFF, 20'h00000, 1'b1, 20'h00000, 13'd3};
    tbl[9] = '{1'b1, 1'b1, 3'd3, 12'h010, 12'h7FF, 20'h55555, 1'b1, 20'h00002, 13'd4};

    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    check("rst.ready", 32'(bus.ready), 0);
    check("rst.done", 32'(bus.done), 0);
    check("rst.wr_count", 32'(bus.wr_count), 0);
    check("rst.idata", 32'(bus.idata), 0);
    check("rst.cdata_rd", 32'(bus.cdata_rd), 0);
    model_reset();
    reset = 0;

    // Preload part of the image, then the directed word at 0x041.
    for (int a = 0; a < 256; a++) begin
      bus.load_en = 1; bus.load_addr = 12'(a); bus.load_data = 20'($urandom);
      tick(); verify("preload");
    end
    bus.load_addr = 12'h041; bus.load_data = 20'h12345;
    tick();
    bus.load_en = 0; bus.iaddr = 12'h041;
    tick(); verify("img");
    check("img.idata_041", 32'(bus.idata), 32'h12345);

    // Directed layer-memory table.
    for (int i = 0; i < 10; i++) begin
      bus.cwr = tbl[i].cwr; bus.crd = tbl[i].crd; bus.csel = tbl[i].csel;
      bus.caddr_wr = tbl[i].wa; bus.caddr_rd = tbl[i].ra; bus.cdata_wr = tbl[i].wd;
      tick(); verify($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.wc", i), 32'(bus.wr_count), 32'(tbl[i].exp_wc));
      if (tbl[i].chk) check($sformatf("tbl%0d.rd", i), 32'(bus.cdata_rd), 32'(tbl[i].exp_rd));
    end
`ifdef LAYER_MEM_CHECK_EN
    check("tbl.err", 32'(bus.err), 1);
`endif
    idle_inputs(); bus.iaddr = 12'h041;

    // Run handshake with a busy-low dwell in ARM and an ignored preload during RUN.
    bus.start = 1; tick(); bus.start = 0; verify("arm");
    check("arm.ready", 32'(bus.ready), 1);
    repeat (3) begin tick(); verify("arm_wait"); end
    check("arm_wait.ready", 32'(bus.ready), 1);
    bus.busy = 1; tick(); verify("run");
    check("run.ready", 32'(bus.ready), 0);
    bus.load_en = 1; bus.load_addr = 12'h041; bus.load_data = 20'h00000;
    repeat (49) begin tick(); verify("run_hold"); end
    bus.load_en = 0; bus.busy = 0;
    tick(); verify("done");
    check("done.done", 32'(bus.done), 1);
    tick(); verify("done_img");
    check("done.idata_041", 32'(bus.idata), 32'h12345);
    bus.start = 1; tick(); bus.start = 0; verify("rearm");
    check("rearm.done", 32'(bus.done), 0);
    check("rearm.wr_count", 32'(bus.wr_count), 0);

    // Asynchronous reset in RUN with a pending write that must be dropped.
    bus.busy = 1; tick(); verify("run2");
    bus.cwr = 1; bus.csel = 3'd1; bus.caddr_wr = 12'h020; bus.cdata_wr = 20'h13579;
    tick(); verify("run2_wr");
    bus.cdata_wr = 20'hFFFFF;
    @(negedge clk); reset = 1; #1;
    check("arst.ready", 32'(bus.ready), 0);
    check("arst.done", 32'(bus.done), 0);
    check("arst.wr_count", 32'(bus.wr_count), 0);
    check("arst.cdata_rd", 32'(bus.cdata_rd), 0);
    @(posedge clk); #1;
    reset = 0; model_reset(); idle_inputs();
    bus.crd = 1; bus.csel = 3'd1; bus.caddr_rd = 12'h020;
    tick(); verify("arst_rd");
    check("arst.l0_kept", 32'(bus.cdata_rd), 32'h13579);
    idle_inputs();

    // Write counter saturation.
    bus.cwr = 1; bus.csel = 3'd1;
    for (int i = 0; i < 8191; i++) begin
      bus.caddr_wr = 12'($urandom_range(0, 31)); bus.cdata_wr = 20'($urandom);
      tick();
    end
    verify("sat");
    check("sat.at_max", 32'(bus.wr_count), 8191);
    repeat (5) tick();
    check("sat.hold", 32'(bus.wr_count), 8191);
    idle_inputs();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) bus.busy = ~bus.busy;
      bus.load_en = $urandom_range(0, 1);
      bus.load_addr = 12'($urandom_range(0, 255)); bus.load_data = 20'($urandom);
      bus.iaddr = 12'($urandom_range(0, 255));
      bus.csel = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (($urandom_range(0, 1) == 1) ? 3'd1 : 3'd3);
      bus.cwr = !bus.start && ($urandom_range(0, 1) == 1);
      bus.crd = $urandom_range(0, 1);
      bus.caddr_wr = 12'($urandom_range(0, 31)) | (($urandom_range(0, 3) == 0) ? 12'hC00 : 12'h000);
      bus.caddr_rd = 12'($urandom_range(0, 31)) | (($urandom_range(0, 3) == 0) ? 12'hC00 : 12'h000);
      bus.cdata_wr = 20'($urandom);
      tick(); verify("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
